// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : imem_boot_loader
//  Purpose  : Boot-time loader for the instruction memory. Takes a 16-bit
//             big-endian word count followed by big-endian instruction bytes
//             over a valid/ready byte stream. Each assembled 32-bit word goes
//             out through the memory write port. The CPU is held until the
//             declared number of words has been written.
//  Options  : LOADER_CHECKSUM_EN - expect one trailing byte equal to the XOR
//             of all data bytes. A mismatch ends the load in ERROR.
//  Revision : 1.0 - initial release
// ============================================================================
module imem_boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    input  logic        reload,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);

    // ------------------------------------------------------------------
    // State encoding
    // FIN is a one-cycle settle state. The final data write (or the
    // empty-program case) passes through it before DONE, so the last
    // mem_we strobe always comes strictly before cpu_hold is released.
    // ------------------------------------------------------------------
    localparam logic [2:0] c_LEN_HI = 3'd0;
    localparam logic [2:0] c_LEN_LO = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_FIN    = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;
    localparam logic [2:0] c_ERROR  = 3'd5;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] c_CSUM   = 3'd6;
`endif

    localparam logic [16:0] c_MAX_WORDS = 17'(MAX_WORDS);

    logic [2:0]  state_q,    state_d;
    logic [15:0] len_q,      len_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [23:0] shift_q,    shift_d;
    logic        we_q,       we_d;
    logic [31:0] addr_q,     addr_d;
    logic [31:0] wdata_q,    wdata_d;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q,     csum_d;
`endif

    logic        w_ready;
    logic        w_xfer;
    logic [15:0] w_len_new;
    logic [31:0] w_word_addr;
    logic        w_last_word;

    // Output decode: handshake and status flags follow the state directly
    always_comb begin
        w_ready  = (state_q == c_LEN_HI) || (state_q == c_LEN_LO) ||
`ifdef LOADER_CHECKSUM_EN
                   (state_q == c_CSUM) ||
`endif
                   (state_q == c_DATA);
        in_ready = w_ready;
        done     = (state_q == c_DONE);
        error    = (state_q == c_ERROR);
        cpu_hold = (state_q != c_DONE);
    end

    assign w_xfer      = in_valid & w_ready;
    assign w_len_new   = {len_q[15:8], in_byte};
    // Word address wraps modulo 2^32; no clamping is intended.
    assign w_word_addr = BASE_ADDR + {14'd0, word_cnt_q, 2'b00};
    assign w_last_word = (word_cnt_q == (len_q - 16'd1));

    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // Next-state logic: byte acceptance, word assembly, write scheduling
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        shift_d    = shift_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            c_LEN_HI: begin
                if (w_xfer) begin
                    len_d[15:8] = in_byte;
                    state_d     = c_LEN_LO;
                end
            end
            c_LEN_LO: begin
                if (w_xfer) begin
                    len_d[7:0] = in_byte;
                    if (w_len_new == 16'd0) begin
                        state_d = c_FIN;
                    end else if ({1'b0, w_len_new} > c_MAX_WORDS) begin
                        state_d = c_ERROR;
                    end else begin
                        state_d = c_DATA;
                    end
                end
            end
            c_DATA: begin
                if (w_xfer) begin
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q ^ in_byte;
`endif
                    if (byte_cnt_q == 2'd3) begin
                        // Fourth byte completes the word; strobe it next cycle
                        we_d       = 1'b1;
                        wdata_d    = {shift_q, in_byte};
                        addr_d     = w_word_addr;
                        word_cnt_d = word_cnt_q + 16'd1;
                        byte_cnt_d = 2'd0;
                        if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
                            state_d = c_CSUM;
`else
                            state_d = c_FIN;
`endif
                        end
                    end else begin
                        shift_d    = {shift_q[15:0], in_byte};
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            c_CSUM: begin
                if (w_xfer) begin
                    state_d = (in_byte == csum_q) ? c_DONE : c_ERROR;
                end
            end
`endif
            c_FIN: begin
                state_d = c_DONE;
            end
            c_DONE, c_ERROR: begin
                if (reload) begin
                    state_d    = c_LEN_HI;
                    len_d      = 16'd0;
                    byte_cnt_d = 2'd0;
                    word_cnt_d = 16'd0;
                    shift_d    = 24'd0;
                    addr_d     = BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = 8'd0;
`endif
                end
            end
            default: begin
                state_d = c_LEN_HI;
            end
        endcase
    end

    // State and datapath registers; reset drops any pending write at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_LEN_HI;
            len_q      <= 16'd0;
            byte_cnt_q <= 2'd0;
            word_cnt_q <= 16'd0;
            shift_q    <= 24'd0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            shift_q    <= shift_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running XOR of data bytes, compared against the trailing byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_q <= 8'd0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_imem_boot_loader
//  Purpose  : Self-checking bench for imem_boot_loader (default build).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_imem_boot_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        reload;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    imem_boot_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (256)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_byte   (in_byte),
        .in_ready  (in_ready),
        .reload    (reload),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log: {addr, data} of every strobe, sampled mid-cycle
    logic [63:0] wq[$];
    always @(negedge clk) begin
        if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        rl;
        logic        rdy;
        logic        we;
        logic [31:0] addr;
        logic        cd;
        logic [31:0] wd;
        logic        hold;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t tv[$];

    logic [7:0] stim [16];
    int         stim_n;

    // Send stim[0..stim_n-1]; tog=1 alternates in_valid 1/0 every cycle
    task automatic send_stream(input bit tog);
        int  idx = 0;
        int  cyc = 0;
        bit  vld;
        bit  rdy;
        while (idx < stim_n && cyc < 400) begin
            @(negedge clk);
            vld      = tog ? ((cyc % 2) == 0) : 1'b1;
            in_valid = vld;
            in_byte  = vld ? stim[idx] : 8'hEE;
            #4;
            rdy = in_ready;
            @(posedge clk);
            if (vld && rdy) idx++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("stream_timeout", 32'(idx), 32'(stim_n));
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", {31'd0, done}, 32'd1);
    endtask

    task automatic load_prog1();
        stim[0] = 8'h00; stim[1] = 8'h02;
        stim[2] = 8'h20; stim[3] = 8'h08; stim[4] = 8'h00; stim[5] = 8'h05;
        stim[6] = 8'h01; stim[7] = 8'h09; stim[8] = 8'h50; stim[9] = 8'h20;
        stim_n  = 10;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        reload   = 1'b0;

        // Cycle table: {v, byte, reload | ready, we, addr, check_wdata, wdata, hold, done, error}
        tv.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h20, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h08, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0,        1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 32'h0, 1'b1, 32'h20080005, 1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20080005, 1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h09, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20080005, 1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h50, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20080005, 1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 32'h4, 1'b1, 32'h01095020, 1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h4, 1'b1, 32'h01095020, 1'b0, 1'b1, 1'b0});
        tv.push_back('{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 32'h4, 1'b1, 32'h01095020, 1'b0, 1'b1, 1'b0});
        // reload, then empty program 00 00
        tv.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0});
        tv.push_back('{1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0});
        // reload, then oversize length 0x0101 = 257
        tv.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1});
        tv.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b1});
        // reload from ERROR, then length exactly 256 is accepted
        tv.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0});
        tv.push_back('{1'b1, 8'hDE, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0});

        // Reset values while rst is held
        #12;
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_we",    {31'd0, mem_we},   32'd0);
        chk("rst_addr",  mem_addr,          32'h0);
        chk("rst_wdata", mem_wdata,         32'h0);
        chk("rst_hold",  {31'd0, cpu_hold}, 32'd1);
        chk("rst_done",  {31'd0, done},     32'd0);
        chk("rst_error", {31'd0, error},    32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            in_valid = tv[i].v;
            in_byte  = tv[i].b;
            reload   = tv[i].rl;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, in_ready}, {31'd0, tv[i].rdy});
            chk($sformatf("v%0d_we", i),    {31'd0, mem_we},   {31'd0, tv[i].we});
            chk($sformatf("v%0d_addr", i),  mem_addr,          tv[i].addr);
            if (tv[i].cd)
                chk($sformatf("v%0d_wdata", i), mem_wdata, tv[i].wd);
            chk($sformatf("v%0d_hold", i),  {31'd0, cpu_hold}, {31'd0, tv[i].hold});
            chk($sformatf("v%0d_done", i),  {31'd0, done},     {31'd0, tv[i].dn});
            chk($sformatf("v%0d_error", i), {31'd0, error},    {31'd0, tv[i].er});
        end
        @(negedge clk);
        in_valid = 1'b0;
        reload   = 1'b0;

        // Toggled in_valid: same writes, same order
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
        load_prog1();
        send_stream(1'b1);
        wait_done();
        chk("tog_nwrites", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("tog_w0", wq[0][63:32], 32'h0);
            chk("tog_d0", wq[0][31:0],  32'h20080005);
            chk("tog_w1", wq[1][63:32], 32'h4);
            chk("tog_d1", wq[1][31:0],  32'h01095020);
        end
        chk("tog_hold", {31'd0, cpu_hold}, 32'd0);

        // Reset after 2 bytes of the second word
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
        stim_n = 8;
        send_stream(1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_we",    {31'd0, mem_we},   32'd0);
        chk("mid_addr",  mem_addr,          32'h0);
        chk("mid_wdata", mem_wdata,         32'h0);
        chk("mid_hold",  {31'd0, cpu_hold}, 32'd1);
        repeat (3) @(negedge clk);
        chk("mid_nwrites", 32'(wq.size()), 32'd1);
        rst = 1'b0;
        wq.delete();
        load_prog1();
        send_stream(1'b0);
        wait_done();
        chk("rel_nwrites", 32'(wq.size()), 32'd2);
        if (wq.size() == 2) begin
            chk("rel_w0", wq[0][63:32], 32'h0);
            chk("rel_d0", wq[0][31:0],  32'h20080005);
            chk("rel_w1", wq[1][63:32], 32'h4);
        end

        // Reset exactly in the cycle the strobe is visible
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        wq.delete();
        stim_n = 6;
        send_stream(1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("strobe_cut_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
